conv_peak_scan: RTL and testbench

CONV_PEAK_SCAN -- requirements
Module: conv_peak_scan

---
 rtl/conv_peak_scan.sv | 170 +++++++++++++++++
 tb/tb_conv_peak_scan.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_peak_scan.sv
// rtl/conv_peak_scan.sv - per-line peak search over a 16-tap convolver window
//
// Streams pixels of a line into a 16-sample shift window that feeds an
// external combinational convolver, tracks the maximum convolver result over
// the line and reports its value and the column of the window centre tap.
//
// Optional feature: define CONV_PEAK_THRESH_EN to report peak_col = 11'h7FF
// whenever the line maximum is below THRESHOLD.
//
// Ports:
//   clk         in   sole clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   pix_valid   in   pixel offered
//   pix_data    in   [7:0] pixel intensity
//   pix_sol     in   start of line, qualified by pix_valid
//   pix_ready   out  pixel accepted when pix_valid && pix_ready
//   window      out  [15:0][7:0] sample window, [15] newest, [0] oldest
//   convvalue   in   [16:0] convolver result for the current window
//   peak_valid  out  per-line result available
//   peak_ready  in   result consumed when peak_valid && peak_ready
//   peak_col    out  [10:0] column of window[8] at the maximum
//   peak_value  out  [16:0] maximum convvalue of the line

module conv_peak_scan #(
  parameter int          LINE_WIDTH = 640,
  parameter logic [16:0] THRESHOLD  = 17'd256
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pix_valid,
  input  logic [7:0]       pix_data,
  input  logic             pix_sol,
  output logic             pix_ready,
  output logic [15:0][7:0] window,
  input  logic [16:0]      convvalue,
  output logic             peak_valid,
  input  logic             peak_ready,
  output logic [10:0]      peak_col,
  output logic [16:0]      peak_value
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FILL   = 3'd1;
  localparam logic [2:0] SCAN   = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] REPORT = 3'd4;

  // Column counter value one before the last column / the last fill column.
  localparam logic [10:0] LAST_M1 = 11'(LINE_WIDTH - 2);
  localparam logic [10:0] FILL_M1 = 11'd14;

  logic [2:0]       state_q,  state_d;
  logic [15:0][7:0] win_q,    win_d;
  logic [10:0]      col_q,    col_d;
  logic             flag_q,   flag_d;
  logic             first_q,  first_d;
  logic [16:0]      max_q,    max_d;
  logic [10:0]      maxcol_q, maxcol_d;
  logic             pv_q,     pv_d;
  logic [10:0]      pcol_q,   pcol_d;
  logic [16:0]      pval_q,   pval_d;

  logic accept;

  assign pix_ready  = (state_q == IDLE) || (state_q == FILL) || (state_q == SCAN);
  assign accept     = pix_valid && pix_ready;
  assign window     = win_q;
  assign peak_valid = pv_q;
  assign peak_col   = pcol_q;
  assign peak_value = pval_q;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    col_d    = col_q;
    flag_d   = 1'b0;
    first_d  = first_q;
    max_d    = max_q;
    maxcol_d = maxcol_q;
    pv_d     = pv_q;
    pcol_d   = pcol_q;
    pval_d   = pval_q;

    // Compare runs on the window that armed the flag; col_q still names
    // window[15] of that window, so window[8] sits 7 columns earlier.
    if (flag_q) begin
      if (first_q || (convvalue > max_q)) begin
        max_d    = convvalue;
        maxcol_d = col_q - 11'd7;
      end
      first_d = 1'b0;
    end

    if (accept) begin
      win_d = {pix_data, win_q[15:1]};
    end

    case (state_q)
      FILL, SCAN: begin
        if (accept && !pix_sol) begin
          col_d  = col_q + 11'd1;
          if (state_q == SCAN) begin
            flag_d = 1'b1;
            if (col_q == LAST_M1) state_d = DRAIN;
          end else if (col_q == FILL_M1) begin
            // Window now holds columns 0..15: the first full window.
            flag_d  = 1'b1;
            state_d = (LINE_WIDTH == 16) ? DRAIN : SCAN;
          end
        end
      end
      DRAIN: begin
        // Final compare lands on this edge, so publish the post-compare max.
        state_d = REPORT;
        pv_d    = 1'b1;
        pval_d  = max_d;
`ifdef CONV_PEAK_THRESH_EN
        pcol_d  = (max_d < THRESHOLD) ? 11'h7FF : maxcol_d;
`else
        pcol_d  = maxcol_d;
`endif
      end
      REPORT: begin
        if (peak_ready) begin
          state_d = IDLE;
          pv_d    = 1'b0;
        end
      end
      default: ;
    endcase

    // Start of line (fresh or restart) overrides everything, including a
    // compare pending on this edge.
    if (accept && pix_sol) begin
      state_d  = FILL;
      col_d    = 11'd0;
      flag_d   = 1'b0;
      first_d  = 1'b1;
      max_d    = 17'd0;
      maxcol_d = 11'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      win_q    <= '0;
      col_q    <= 11'd0;
      flag_q   <= 1'b0;
      first_q  <= 1'b0;
      max_q    <= 17'd0;
      maxcol_q <= 11'd0;
      pv_q     <= 1'b0;
      pcol_q   <= 11'd0;
      pval_q   <= 17'd0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      col_q    <= col_d;
      flag_q   <= flag_d;
      first_q  <= first_d;
      max_q    <= max_d;
      maxcol_q <= maxcol_d;
      pv_q     <= pv_d;
      pcol_q   <= pcol_d;
      pval_q   <= pval_d;
    end
  end

endmodule

// File: tb/tb_conv_peak_scan.sv
// tb/tb_conv_peak_scan.sv - scoreboard bench for conv_peak_scan
module tb_conv_peak_scan;

  localparam int          LW = 32;
  localparam logic [16:0] TH = 17'd100;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             pix_valid;
  logic [7:0]       pix_data;
  logic             pix_sol;
  logic             pix_ready;
  logic [15:0][7:0] window;
  logic [16:0]      convvalue;
  logic             peak_valid;
  logic             peak_ready;
  logic [10:0]      peak_col;
  logic [16:0]      peak_value;

  int n_checks = 0;
  int n_fail   = 0;
  int n_results = 0;

  logic [7:0]  line_pix [0:LW-1];
  logic [27:0] exp_q [$];
  logic [27:0] mon_e;

  assign convvalue = {9'd0, window[8]};

  conv_peak_scan #(.LINE_WIDTH(LW), .THRESHOLD(TH)) dut (
    .clk(clk), .reset_n(reset_n),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_sol(pix_sol),
    .pix_ready(pix_ready), .window(window), .convvalue(convvalue),
    .peak_valid(peak_valid), .peak_ready(peak_ready),
    .peak_col(peak_col), .peak_value(peak_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Earliest maximum over the centre-tap columns 8..LW-8.
  function automatic logic [27:0] model();
    logic [16:0] best = 17'd0;
    logic [10:0] bc   = 11'd0;
    for (int c = 8; c <= LW - 8; c++) begin
      if (c == 8 || {9'd0, line_pix[c]} > best) begin
        best = {9'd0, line_pix[c]};
        bc   = 11'(c);
      end
    end
`ifdef CONV_PEAK_THRESH_EN
    if (best < TH) bc = 11'h7FF;
`endif
    return {bc, best};
  endfunction

  task automatic fill_line(input logic [7:0] bg);
    for (int c = 0; c < LW; c++) line_pix[c] = bg;
  endtask

  task automatic send_pix(input logic [7:0] d, input logic sol);
    int n = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sol   = sol;
    @(negedge clk);
    while (!pix_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sol   = 1'b0;
  endtask

  task automatic send_line(input int n, input bit gap, input bit push);
    if (push) exp_q.push_back(model());
    for (int c = 0; c < n; c++) begin
      send_pix(line_pix[c], c == 0);
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && peak_valid && peak_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("peak_col", 64'(peak_col), 64'(mon_e[27:17]));
        check("peak_value", 64'(peak_value), 64'(mon_e[16:0]));
        n_results++;
      end
    end
  end

  initial begin
    reset_n = 1'b0; pix_valid = 1'b0; pix_data = 8'd0; pix_sol = 1'b0; peak_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix_ready", 64'(pix_ready), 64'd1);
    check("rst_peak_valid", 64'(peak_valid), 64'd0);
    check("rst_peak_col", 64'(peak_col), 64'd0);
    check("rst_peak_value", 64'(peak_value), 64'd0);
    check("rst_window_zero", 64'(window == '0), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single peak at col 20; timing through DRAIN/REPORT.
    fill_line(8'd10);
    line_pix[20] = 8'd200;
    send_line(LW, 1'b0, 1'b1);
    check("win15_last", 64'(window[15]), 64'(line_pix[LW-1]));
    check("win0_oldest", 64'(window[0]), 64'(line_pix[LW-16]));
    @(negedge clk);
    check("drain_pix_ready", 64'(pix_ready), 64'd0);
    check("drain_peak_valid", 64'(peak_valid), 64'd0);
    @(negedge clk);
    check("report_peak_valid", 64'(peak_valid), 64'd1);
    repeat (3) @(negedge clk);
    check("back_idle_ready", 64'(pix_ready), 64'd1);

    // Tie at cols 12 and 18, consumer stalls for 5 cycles.
    fill_line(8'd0);
    line_pix[12] = 8'd90;
    line_pix[18] = 8'd90;
    @(posedge clk);
    #1;
    peak_ready = 1'b0;
    send_line(LW, 1'b0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_peak_valid", 64'(peak_valid), 64'd1);
      check("stall_peak_col", 64'(peak_col), 64'd12);
      check("stall_pix_ready", 64'(pix_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    peak_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("stall_release_idle", 64'(pix_ready), 64'd1);
    check("stall_release_valid", 64'(peak_valid), 64'd0);

    // Restart at col 25: first line abandoned.
    fill_line(8'd10);
    line_pix[10] = 8'd250;
    send_line(25, 1'b0, 1'b0);
    fill_line(8'd10);
    line_pix[9] = 8'd60;
    send_line(LW, 1'b0, 1'b1);
    repeat (4) @(negedge clk);

    // pix_valid every other cycle.
    fill_line(8'd5);
    line_pix[23] = 8'd77;
    send_line(LW, 1'b1, 1'b1);
    repeat (4) @(negedge clk);

    // Reset mid-line at col 19.
    fill_line(8'd10);
    line_pix[12] = 8'd180;
    send_line(20, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("midrst_pix_ready", 64'(pix_ready), 64'd1);
    check("midrst_peak_valid", 64'(peak_valid), 64'd0);
    check("midrst_window_zero", 64'(window == '0), 64'd1);
    check("midrst_peak_value", 64'(peak_value), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send_pix(8'd222, 1'b0);
    repeat (4) @(negedge clk);
    check("idle_no_result", 64'(peak_valid), 64'd0);
    fill_line(8'd10);
    line_pix[14] = 8'd150;
    send_line(LW, 1'b0, 1'b1);
    repeat (4) @(negedge clk);

    // Threshold boundary: 99 below, 100 at threshold.
    fill_line(8'd10);
    line_pix[15] = 8'd99;
    send_line(LW, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    fill_line(8'd10);
    line_pix[16] = 8'd100;
    send_line(LW, 1'b0, 1'b1);
    repeat (4) @(negedge clk);

    check("results_count", 64'(n_results), 64'd7);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
